axi_rd_rr_arbiter: RTL and testbench

- N-master to 1-slave arbiter for the AXI read path (AR/R channels), single-beat transactions, one transaction outstanding.
- Sits between the fetch/load requesters (IFU = master 0, LSU = master 1 in the default build) and the shared memory port.
- Grants by round-robin and locks the grant from the AR handshake until the R handshake.
- Replaces ad-hoc read muxing with a proper fair scheduler.

---
 rtl/axi_rd_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axi_rd_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_rr_arbiter.sv
// axi_rd_rr_arbiter: N-master to 1-slave AXI read-path arbiter, single beat,
// one transaction outstanding. The grant is held from AR handshake to R handshake.
// Optional build macro AXI_RD_ARB_FIXED_PRIO_EN: highest index wins, no rr pointer.
module axi_rd_rr_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_MASTERS-1:0]                  m_ar_valid_i,
  output logic [N_MASTERS-1:0]                  m_ar_ready_o,
  input  logic [N_MASTERS*AXI_ADDR_WIDTH-1:0]   m_ar_addr_i,
  output logic [N_MASTERS-1:0]                  m_r_valid_o,
  input  logic [N_MASTERS-1:0]                  m_r_ready_i,
  output logic [2*N_MASTERS-1:0]                m_r_resp_o,
  output logic [N_MASTERS*AXI_DATA_WIDTH-1:0]   m_r_data_o,
  output logic                                  s_ar_valid_o,
  input  logic                                  s_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]             s_ar_addr_o,
  input  logic                                  s_r_valid_i,
  output logic                                  s_r_ready_o,
  input  logic [1:0]                            s_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0]             s_r_data_i,
  output logic [((N_MASTERS > 1) ? $clog2(N_MASTERS) : 1)-1:0] grant_o,
  output logic                                  busy_o
);

  localparam int unsigned N  = N_MASTERS;
  localparam int unsigned AW = AXI_ADDR_WIDTH;
  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] w_grant_nxt;
  logic [GW-1:0] w_win;
  logic          w_any;
  logic          w_sel_ar_valid;
  logic          w_sel_r_ready;
  logic [AW-1:0] w_sel_addr;

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] w_rr_ptr_nxt;
  logic [GW-1:0] w_grant_inc;
  logic [N-1:0]  w_rot;
  logic [GW-1:0] w_off;
  logic [GW:0]   w_sum;
`endif

  assign w_any = |m_ar_valid_i;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // Fixed priority: highest requesting index wins.
  always_comb begin
    w_win = '0;
    for (int k = 0; k < N; k++) begin
      if (m_ar_valid_i[k]) w_win = GW'(k);
    end
  end
`else
  // Round robin: rotate requests so rr_ptr is bit 0, take first set bit, rotate back.
  always_comb begin
    w_rot = N'({m_ar_valid_i, m_ar_valid_i} >> r_rr_ptr);
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = GW'(k);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (GW+1)'(N)) w_sum = w_sum - (GW+1)'(N);
    w_win = w_sum[GW-1:0];
  end

  assign w_grant_inc = (r_grant == GW'(N - 1)) ? '0 : r_grant + GW'(1);
`endif

  // Mux out the owner's request-side signals.
  always_comb begin
    w_sel_ar_valid = 1'b0;
    w_sel_r_ready  = 1'b0;
    w_sel_addr     = '0;
    for (int k = 0; k < N; k++) begin
      if (GW'(k) == r_grant) begin
        w_sel_ar_valid = m_ar_valid_i[k];
        w_sel_r_ready  = m_r_ready_i[k];
        w_sel_addr     = m_ar_addr_i[k*AW +: AW];
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      r_rr_ptr <= w_rr_ptr_nxt;
`endif
    end
  end

  // Next-state: arbitrate in IDLE, lock grant through ADDR and DATA.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    w_rr_ptr_nxt = r_rr_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        // A dropped request abandons the slot without issuing anything.
        if (!w_sel_ar_valid)   w_state_nxt = S_IDLE;
        else if (s_ar_ready_i) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (s_r_valid_i && w_sel_r_ready) begin
          w_state_nxt  = S_IDLE;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
          w_rr_ptr_nxt = w_grant_inc;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; reset forces everything quiet so an abandoned response is not forwarded.
  always_comb begin
    m_ar_ready_o = '0;
    m_r_valid_o  = '0;
    m_r_data_o   = '0;
    m_r_resp_o   = '0;
    s_ar_valid_o = 1'b0;
    s_ar_addr_o  = '0;
    s_r_ready_o  = 1'b0;
    grant_o      = '0;
    busy_o       = 1'b0;
    if (!rst) begin
      grant_o = r_grant;
      busy_o  = (r_state == S_ADDR) || (r_state == S_DATA);
      if (r_state == S_ADDR) begin
        s_ar_valid_o = w_sel_ar_valid;
        s_ar_addr_o  = w_sel_addr;
      end
      if (r_state == S_DATA) s_r_ready_o = w_sel_r_ready;
      for (int k = 0; k < N; k++) begin
        if (GW'(k) == r_grant) begin
          if (r_state == S_ADDR) m_ar_ready_o[k] = s_ar_ready_i;
          if (r_state == S_DATA) begin
            m_r_valid_o[k]           = s_r_valid_i;
            m_r_data_o[k*DW +: DW]   = s_r_data_i;
            m_r_resp_o[2*k +: 2]     = s_r_resp_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Directed self-checking bench for axi_rd_rr_arbiter (2 masters, 32b addr, 64b data).
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_axi_rd_rr_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_ar_valid_i;
  logic [N-1:0]    m_ar_ready_o;
  logic [N*AW-1:0] m_ar_addr_i;
  logic [N-1:0]    m_r_valid_o;
  logic [N-1:0]    m_r_ready_i;
  logic [2*N-1:0]  m_r_resp_o;
  logic [N*DW-1:0] m_r_data_o;
  logic            s_ar_valid_o;
  logic            s_ar_ready_i;
  logic [AW-1:0]   s_ar_addr_o;
  logic            s_r_valid_i;
  logic            s_r_ready_o;
  logic [1:0]      s_r_resp_i;
  logic [DW-1:0]   s_r_data_i;
  logic [0:0]      grant_o;
  logic            busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [AW-1:0] ADDR0 = 32'h8000_0000;
  localparam logic [AW-1:0] ADDR1 = 32'h9000_0040;

  axi_rd_rr_arbiter #(.N_MASTERS(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m_ar_valid_i(m_ar_valid_i), .m_ar_ready_o(m_ar_ready_o), .m_ar_addr_i(m_ar_addr_i),
    .m_r_valid_o(m_r_valid_o), .m_r_ready_i(m_r_ready_i), .m_r_resp_o(m_r_resp_o),
    .m_r_data_o(m_r_data_o),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i), .s_ar_addr_o(s_ar_addr_o),
    .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o), .s_r_resp_i(s_r_resp_i),
    .s_r_data_i(s_r_data_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_ar_valid_i = '0;
    m_r_ready_i  = '0;
    s_ar_ready_i = 1'b0;
    s_r_valid_i  = 1'b0;
    s_r_resp_i   = 2'b00;
    s_r_data_i   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ar_addr_i  = {ADDR1, ADDR0};
    m_ar_valid_i = 2'b11;
    m_r_ready_i  = 2'b11;
    s_ar_ready_i = 1'b1;
    s_r_valid_i  = 1'b1;
    s_r_resp_i   = 2'b11;
    s_r_data_i   = 64'hDEAD_BEEF_0000_0001;
    tick(); tick(); tick();
    settle();
    n_tests++;
    if ({s_ar_valid_o, s_r_ready_o, busy_o, grant_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 0000", {s_ar_valid_o, s_r_ready_o, busy_o, grant_o});
    end
    n_tests++;
    if ({m_ar_ready_o, m_r_valid_o, m_r_resp_o} !== 8'h00) begin
      n_fail++; $display("FAIL reset_master: got %h exp 00", {m_ar_ready_o, m_r_valid_o, m_r_resp_o});
    end
    n_tests++;
    if ((m_r_data_o !== '0) || (s_ar_addr_o !== '0)) begin
      n_fail++; $display("FAIL reset_data: got data %h addr %h exp 0", m_r_data_o, s_ar_addr_o);
    end
    // Release; first grant is master 0, then abandon the transaction with reset in DATA.
    s_ar_ready_i = 1'b0;
    s_r_valid_i  = 1'b0;
    tick(); rst = 1'b0;
    tick();
    n_tests++;
    if ({busy_o, grant_o, s_ar_valid_o} !== 3'b101 || s_ar_addr_o !== ADDR0) begin
      n_fail++; $display("FAIL reset_first_grant: got busy/grant/arv %b addr %h exp 101 %h",
                         {busy_o, grant_o, s_ar_valid_o}, s_ar_addr_o, ADDR0);
    end
    s_ar_ready_i = 1'b1;
    tick();
    m_ar_valid_i = 2'b00;
    s_ar_ready_i = 1'b0;
    rst = 1'b1;
    s_r_valid_i = 1'b1;
    settle();
    n_tests++;
    if ({m_r_valid_o, s_r_ready_o, busy_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_txn: got rvalid/rready/busy %b exp 0000", {m_r_valid_o, s_r_ready_o, busy_o});
    end
    tick();
    rst = 1'b0;
    s_r_valid_i = 1'b0;
    settle();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_abandon_idle: got busy %b exp 0", busy_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    // IDLE: request appears together with a stray slave R valid.
    m_ar_valid_i = 2'b01;
    m_r_ready_i  = 2'b01;
    s_ar_ready_i = 1'b1;
    s_r_valid_i  = 1'b1;
    settle();
    n_tests++;
    if ({s_ar_valid_o, m_ar_ready_o, s_r_ready_o, m_r_valid_o} !== 6'b0) begin
      n_fail++; $display("FAIL single_idle_quiet: got %b exp 000000", {s_ar_valid_o, m_ar_ready_o, s_r_ready_o, m_r_valid_o});
    end
    tick();
    n_tests++;
    if (s_ar_valid_o !== 1'b1 || s_ar_addr_o !== ADDR0 || m_ar_ready_o !== 2'b01) begin
      n_fail++; $display("FAIL single_ar: got v %b addr %h rdy %b exp 1 %h 01", s_ar_valid_o, s_ar_addr_o, m_ar_ready_o, ADDR0);
    end
    n_tests++;
    if (m_r_valid_o !== 2'b00 || s_r_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL single_r_ignored_addr: got rvalid %b rready %b exp 00 0", m_r_valid_o, s_r_ready_o);
    end
    tick();
    m_ar_valid_i = 2'b00;
    s_r_valid_i  = 1'b0;
    settle();
    n_tests++;
    if (s_r_ready_o !== 1'b1 || m_r_valid_o !== 2'b00 || busy_o !== 1'b1 || s_ar_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_data_wait: got rready %b rvalid %b busy %b arv %b exp 1 00 1 0",
                         s_r_ready_o, m_r_valid_o, busy_o, s_ar_valid_o);
    end
    tick();
    tick();
    s_r_valid_i = 1'b1;
    s_r_data_i  = 64'h1122_3344_5566_7788;
    s_r_resp_i  = 2'b00;
    settle();
    n_tests++;
    if (m_r_valid_o !== 2'b01 || m_r_data_o[63:0] !== 64'h1122_3344_5566_7788 ||
        m_r_data_o[127:64] !== 64'h0 || m_r_resp_o !== 4'b0000) begin
      n_fail++; $display("FAIL single_r_fwd: got v %b data %h resp %b exp 01 00000000000000001122334455667788 0000",
                         m_r_valid_o, m_r_data_o, m_r_resp_o);
    end
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_back_idle: got busy %b exp 0", busy_o);
    end
  endtask

  task automatic test_stall();
    // Master 1 alone; slave withholds AR ready for 5 cycles.
    m_ar_valid_i = 2'b10;
    m_r_ready_i  = 2'b10;
    tick();
    m_ar_valid_i = 2'b11;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_tests++;
      if (s_ar_valid_o !== 1'b1 || grant_o !== 1'b1 || m_ar_ready_o !== 2'b00 || s_ar_addr_o !== ADDR1) begin
        n_fail++; $display("FAIL stall_ar_hold[%0d]: got arv %b grant %b rdy %b addr %h exp 1 1 00 %h",
                           c, s_ar_valid_o, grant_o, m_ar_ready_o, s_ar_addr_o, ADDR1);
      end
      tick();
    end
    s_ar_ready_i = 1'b1;
    settle();
    n_tests++;
    if (m_ar_ready_o !== 2'b10) begin
      n_fail++; $display("FAIL stall_ar_ready: got %b exp 10", m_ar_ready_o);
    end
    tick();
    // DATA: master 1 withholds R ready for 3 cycles; master 0 still requesting.
    m_ar_valid_i = 2'b01;
    m_r_ready_i  = 2'b00;
    s_r_valid_i  = 1'b1;
    s_r_resp_i   = 2'b10;
    s_r_data_i   = 64'hA5A5_0000_FFFF_1234;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_tests++;
      if (s_r_ready_o !== 1'b0 || busy_o !== 1'b1 || grant_o !== 1'b1 || m_r_valid_o !== 2'b10 ||
          m_ar_ready_o !== 2'b00) begin
        n_fail++; $display("FAIL stall_r_hold[%0d]: got rready %b busy %b grant %b rvalid %b arrdy %b exp 0 1 1 10 00",
                           c, s_r_ready_o, busy_o, grant_o, m_r_valid_o, m_ar_ready_o);
      end
      tick();
    end
    m_r_ready_i  = 2'b10;
    m_ar_valid_i = 2'b00;
    settle();
    n_tests++;
    if (s_r_ready_o !== 1'b1 || m_r_data_o[127:64] !== 64'hA5A5_0000_FFFF_1234 ||
        m_r_data_o[63:0] !== 64'h0 || m_r_resp_o !== 4'b1000) begin
      n_fail++; $display("FAIL stall_r_fwd: got rready %b data %h resp %b exp 1 a5a50000ffff12340000000000000000 1000",
                         s_r_ready_o, m_r_data_o, m_r_resp_o);
    end
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_back_idle: got busy %b exp 0", busy_o);
    end
  endtask

  // Both masters request continuously with a zero-wait slave; exp_seq packs 4 expected grants.
  task automatic test_back_to_back(input logic [3:0] exp_seq);
    logic [3:0] seq;
    seq = exp_seq;
    m_ar_valid_i = 2'b11;
    m_r_ready_i  = 2'b11;
    s_ar_ready_i = 1'b1;
    s_r_valid_i  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      settle();
      n_tests++;
      if (busy_o !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle_bubble[%0d]: got busy %b exp 0", t, busy_o);
      end
      tick();
      n_tests++;
      if (busy_o !== 1'b1 || grant_o !== seq[t] || s_ar_valid_o !== 1'b1 ||
          s_ar_addr_o !== (seq[t] ? ADDR1 : ADDR0)) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got busy %b grant %b arv %b addr %h exp 1 %b 1",
                           t, busy_o, grant_o, s_ar_valid_o, s_ar_addr_o, seq[t]);
      end
      tick();
      n_tests++;
      if (m_r_valid_o !== (seq[t] ? 2'b10 : 2'b01) || s_r_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b rready %b exp onehot of %b, 1",
                           t, m_r_valid_o, s_r_ready_o, seq[t]);
      end
      if (t == 3) m_ar_valid_i = 2'b00;
      tick();
    end
    idle_inputs();
    settle();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end_idle: got busy %b exp 0", busy_o);
    end
  endtask

  task automatic test_drop();
    m_ar_valid_i = 2'b01;
    tick();
    n_tests++;
    if (grant_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL drop_grant0: got grant %b busy %b exp 0 1", grant_o, busy_o);
    end
    m_ar_valid_i = 2'b10;
    settle();
    n_tests++;
    if (s_ar_valid_o !== 1'b0 || m_ar_ready_o !== 2'b00) begin
      n_fail++; $display("FAIL drop_no_ar: got arv %b rdy %b exp 0 00", s_ar_valid_o, m_ar_ready_o);
    end
    tick();
    n_tests++;
    if (busy_o !== 1'b0 || s_ar_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: got busy %b arv %b exp 0 0", busy_o, s_ar_valid_o);
    end
    tick();
    n_tests++;
    if (grant_o !== 1'b1 || s_ar_valid_o !== 1'b1 || s_ar_addr_o !== ADDR1) begin
      n_fail++; $display("FAIL drop_next_m1: got grant %b arv %b addr %h exp 1 1 %h", grant_o, s_ar_valid_o, s_ar_addr_o, ADDR1);
    end
    s_ar_ready_i = 1'b1;
    m_r_ready_i  = 2'b10;
    tick();
    m_ar_valid_i = 2'b00;
    s_r_valid_i  = 1'b1;
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL drop_end_idle: got busy %b exp 0", busy_o);
    end
  endtask

  initial begin
    idle_inputs();
    m_ar_addr_i = {ADDR1, ADDR0};
    rst = 1'b1;
    test_reset();
    test_single();
    test_stall();
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    test_back_to_back(4'b1111);
`else
    // Pointer is 0 after master 1's transaction: 0,1,0,1 (bit t = grant of txn t).
    test_back_to_back(4'b1010);
`endif
    test_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
